// File: rtl/piano_note_pkg.sv
// rtl/piano_note_pkg.sv - note encoding, classification windows and timing limits for tone_detector
package piano_note_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCK    = 2'd2
    } fsm_state_t;

    localparam int HP_W = 19;

    localparam logic [3:0] NOTE_C4  = 4'd0;
    localparam logic [3:0] NOTE_D   = 4'd1;
    localparam logic [3:0] NOTE_E   = 4'd2;
    localparam logic [3:0] NOTE_F   = 4'd3;
    localparam logic [3:0] NOTE_G   = 4'd4;
    localparam logic [3:0] NOTE_A   = 4'd5;
    localparam logic [3:0] NOTE_B   = 4'd6;
    localparam logic [3:0] NOTE_C5  = 4'd7;
    localparam logic [3:0] NOTE_OOR = 4'd15;

    // Half-open windows LO <= half_period < HI, in CLK cycles at 100 MHz
    localparam logic [HP_W-1:0] C4_LO = 19'd180687;
    localparam logic [HP_W-1:0] C4_HI = 19'd196842;
    localparam logic [HP_W-1:0] D_LO  = 19'd160975;
    localparam logic [HP_W-1:0] D_HI  = 19'd180687;
    localparam logic [HP_W-1:0] E_LO  = 19'd147428;
    localparam logic [HP_W-1:0] E_HI  = 19'd160975;
    localparam logic [HP_W-1:0] F_LO  = 19'd135361;
    localparam logic [HP_W-1:0] F_HI  = 19'd147428;
    localparam logic [HP_W-1:0] G_LO  = 19'd120593;
    localparam logic [HP_W-1:0] G_HI  = 19'd135361;
    localparam logic [HP_W-1:0] A_LO  = 19'd107437;
    localparam logic [HP_W-1:0] A_HI  = 19'd120593;
    localparam logic [HP_W-1:0] B_LO  = 19'd98398;
    localparam logic [HP_W-1:0] B_HI  = 19'd107437;
    localparam logic [HP_W-1:0] C5_LO = 19'd92690;
    localparam logic [HP_W-1:0] C5_HI = 19'd98398;

    localparam logic [HP_W-1:0] TIMEOUT_CYCLES = 19'd524287;
    localparam logic [HP_W-1:0] GLITCH_CYCLES  = 19'd1024;
    localparam logic [2:0]      LOCK_MATCHES   = 3'd4;

    function automatic logic [3:0] classify_note(input logic [HP_W-1:0] hp);
        logic [3:0] cls;
        cls = NOTE_OOR;
        if      (hp >= C4_LO && hp < C4_HI) cls = NOTE_C4;
        else if (hp >= D_LO  && hp < D_HI)  cls = NOTE_D;
        else if (hp >= E_LO  && hp < E_HI)  cls = NOTE_E;
        else if (hp >= F_LO  && hp < F_HI)  cls = NOTE_F;
        else if (hp >= G_LO  && hp < G_HI)  cls = NOTE_G;
        else if (hp >= A_LO  && hp < A_HI)  cls = NOTE_A;
        else if (hp >= B_LO  && hp < B_HI)  cls = NOTE_B;
        else if (hp >= C5_LO && hp < C5_HI) cls = NOTE_C5;
        return cls;
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// rtl/tone_edge_sync.sv - two-flop synchronizer with registered both-edge detect on TONE_IN
module tone_edge_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic TONE_IN,
    output logic EDGE
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronize, keep a third copy for edge compare, register the edge pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            EDGE  <= 1'b0;
        end else begin
            sync1 <= TONE_IN;
            sync2 <= sync1;
            sync3 <= sync2;
            EDGE  <= sync2 ^ sync3;
        end
    end

endmodule

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - half-period note classifier with lock FSM; TONE_GLITCH_FILTER_EN drops sub-1024-cycle edges
import piano_note_pkg::*;

module tone_detector (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            TONE_IN,
    output logic            NOTE_VALID,
    output logic [3:0]      NOTE_IDX,
    output logic [HP_W-1:0] HALF_PERIOD,
    output logic            LOCKED
);

    fsm_state_t      state;
    fsm_state_t      state_n;
    logic [HP_W-1:0] cnt;
    logic [HP_W-1:0] cnt_n;
    logic [HP_W-1:0] hp_n;
    logic [2:0]      match;
    logic [2:0]      match_n;
    logic [3:0]      idx_n;
    logic [3:0]      meas_class;
    logic            valid_n;
    logic            locked_n;
    logic            edge_pulse;
    logic            accept;
    logic            same_class;

    tone_edge_sync u_edge_sync (
        .CLK     (CLK),
        .RESET   (RESET),
        .TONE_IN (TONE_IN),
        .EDGE    (edge_pulse)
    );

`ifdef TONE_GLITCH_FILTER_EN
    // The arming edge has no reference, so only later edges can be rejected as glitches
    assign accept = edge_pulse && ((state == ST_IDLE) || (cnt >= GLITCH_CYCLES));
`else
    assign accept = edge_pulse;
`endif

    assign meas_class = classify_note(cnt);
    assign same_class = (meas_class != NOTE_OOR) && (meas_class == NOTE_IDX);

    // Next-state, counter and output decode for each accepted edge or timeout
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        match_n  = match;
        valid_n  = 1'b0;
        idx_n    = NOTE_IDX;
        hp_n     = HALF_PERIOD;
        locked_n = LOCKED;
        if (accept) begin
            cnt_n = {{(HP_W-1){1'b0}}, 1'b1};
            if (state == ST_IDLE) begin
                state_n = ST_MEASURE;
            end else begin
                valid_n = 1'b1;
                hp_n    = cnt;
                idx_n   = meas_class;
                if (meas_class == NOTE_OOR)
                    match_n = 3'd0;
                else if (same_class)
                    match_n = (match >= LOCK_MATCHES) ? LOCK_MATCHES : match + 3'd1;
                else
                    match_n = 3'd1;
                if (state == ST_LOCK && !same_class) begin
                    locked_n = 1'b0;
                    state_n  = ST_MEASURE;
                end else if (match_n == LOCK_MATCHES) begin
                    locked_n = 1'b1;
                    state_n  = ST_LOCK;
                end
            end
        end else if (state != ST_IDLE) begin
            if (cnt == TIMEOUT_CYCLES) begin
                state_n  = ST_IDLE;
                cnt_n    = '0;
                match_n  = 3'd0;
                idx_n    = NOTE_OOR;
                hp_n     = '0;
                locked_n = 1'b0;
            end else begin
                cnt_n = cnt + {{(HP_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            match       <= 3'd0;
            NOTE_VALID  <= 1'b0;
            NOTE_IDX    <= NOTE_OOR;
            HALF_PERIOD <= '0;
            LOCKED      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            match       <= match_n;
            NOTE_VALID  <= valid_n;
            NOTE_IDX    <= idx_n;
            HALF_PERIOD <= hp_n;
            LOCKED      <= locked_n;
        end
    end

endmodule
